// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready request/result handshake.
// Logic, add/sub and shifts finish in one cycle; unsigned multiply takes WORD_LEN shift-add steps.
module alu_seq #(
   parameter int WORD_LEN  = 64,
   parameter int SHAMT_LEN = $clog2(WORD_LEN)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [WORD_LEN-1:0] op_a_i,
   input  logic [WORD_LEN-1:0] op_b_i,
   input  logic [3:0]          opc_i,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [WORD_LEN-1:0] op_res_o,
   output logic                flag_z_o,
   output logic                flag_n_o,
   output logic                flag_c_o,
   output logic                flag_v_o,
   output logic                err_o
);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

   state_e                  state_q;
   logic [WORD_LEN-1:0]     opA_q;
   logic [2*WORD_LEN-1:0]   acc_q;
   logic [SHAMT_LEN-1:0]    cnt_q;
   logic [WORD_LEN-1:0]     res_q;
   logic                    flagZ_q, flagN_q, flagC_q, flagV_q, err_q;

   logic [WORD_LEN-1:0]     aluRes_d;
   logic                    aluC_d, aluV_d, aluErr_d;
   logic [WORD_LEN:0]       sum_d;
   logic [SHAMT_LEN-1:0]    shamt_d;
   logic [WORD_LEN:0]       mulSum_d;
   logic [2*WORD_LEN-1:0]   acc_d;

   // Single-cycle result, computed straight from the request inputs.
   always_comb begin
      aluRes_d = '0;
      aluC_d   = 1'b0;
      aluV_d   = 1'b0;
      aluErr_d = 1'b0;
      sum_d    = '0;
      shamt_d  = op_b_i[SHAMT_LEN-1:0];
      case (opc_i)
         4'd0: begin
            sum_d    = {1'b0, op_a_i} + {1'b0, op_b_i};
            aluRes_d = sum_d[WORD_LEN-1:0];
            aluC_d   = sum_d[WORD_LEN];
            aluV_d   = (op_a_i[WORD_LEN-1] == op_b_i[WORD_LEN-1]) &&
                       (aluRes_d[WORD_LEN-1] != op_a_i[WORD_LEN-1]);
         end
         4'd1: begin
            sum_d    = {1'b0, op_a_i} - {1'b0, op_b_i};
            aluRes_d = sum_d[WORD_LEN-1:0];
            aluC_d   = sum_d[WORD_LEN];
            aluV_d   = (op_a_i[WORD_LEN-1] != op_b_i[WORD_LEN-1]) &&
                       (aluRes_d[WORD_LEN-1] != op_a_i[WORD_LEN-1]);
         end
         4'd2: aluRes_d = op_a_i & op_b_i;
         4'd3: aluRes_d = op_a_i | op_b_i;
         4'd4: aluRes_d = op_a_i ^ op_b_i;
         4'd5: aluRes_d = op_a_i << shamt_d;
         4'd6: aluRes_d = op_a_i >> shamt_d;
         4'd7: aluRes_d = $signed(op_a_i) >>> shamt_d;
         4'd8: aluRes_d = '0;
         default: aluErr_d = 1'b1;
      endcase
   end

   // Low half of the accumulator starts as B; each step adds A into the high half on B's LSB and shifts right.
   always_comb begin
      mulSum_d = {1'b0, acc_q[2*WORD_LEN-1:WORD_LEN]} + (acc_q[0] ? {1'b0, opA_q} : '0);
      acc_d    = {mulSum_d, acc_q[WORD_LEN-1:1]};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         opA_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         flagZ_q <= 1'b0;
         flagN_q <= 1'b0;
         flagC_q <= 1'b0;
         flagV_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  if (opc_i == 4'd8) begin
                     opA_q   <= op_a_i;
                     acc_q   <= {{WORD_LEN{1'b0}}, op_b_i};
                     cnt_q   <= '0;
                     err_q   <= 1'b0;
                     state_q <= MUL;
                  end else begin
                     res_q   <= aluRes_d;
                     flagZ_q <= !aluErr_d && (aluRes_d == '0);
                     flagN_q <= aluRes_d[WORD_LEN-1];
                     flagC_q <= aluC_d;
                     flagV_q <= aluV_d;
                     err_q   <= aluErr_d;
                     state_q <= DONE;
                  end
               end
            end
            MUL: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + SHAMT_LEN'(1);
               if (cnt_q == SHAMT_LEN'(WORD_LEN - 1)) begin
                  res_q   <= acc_d[WORD_LEN-1:0];
                  flagZ_q <= (acc_d[WORD_LEN-1:0] == '0);
                  flagN_q <= acc_d[WORD_LEN-1];
                  flagC_q <= |acc_d[2*WORD_LEN-1:WORD_LEN];
                  flagV_q <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (res_ready_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign res_valid_o = (state_q == DONE);
   assign op_res_o    = res_q;
   assign flag_z_o    = flagZ_q;
   assign flag_n_o    = flagN_q;
   assign flag_c_o    = flagC_q;
   assign flag_v_o    = flagV_q;
   assign err_o       = err_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the combinational on-core ALU. Accepts one operation at a time over a valid/ready handshake. Executes logic, arithmetic and shift ops in one cycle, and an unsigned multiply iteratively over WORD_LEN cycles. Returns a registered result plus status flags to the execute stage.

Parameters:
WORD_LEN, 64, operand/result width in bits; must be a power of two, >= 8
SHAMT_LEN, $clog2(WORD_LEN), derived; shift-amount bits taken from op_b_i

Ports:
clk_i  input  1  core clock; all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
req_valid_i  input  1  operand/opcode request valid
req_ready_o  output  1  block can accept a request this cycle
op_a_i  input  WORD_LEN  operand A
op_b_i  input  WORD_LEN  operand B
opc_i  input  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 SAR, 8 MUL, 9-15 illegal
res_valid_o  output  1  result and flags valid
res_ready_i  input  1  consumer takes result this cycle
op_res_o  output  WORD_LEN  operation result
flag_z_o  output  1  result == 0
flag_n_o  output  1  result MSB
flag_c_o  output  1  carry/borrow/unsigned-overflow (see below)
flag_v_o  output  1  signed overflow (ADD/SUB only)
err_o  output  1  illegal opcode was issued

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready_o=1; res_valid_o=0; op_res_o, all flags and err_o = 0; multiply accumulator and counter cleared.
- Reset asserted mid-operation (MUL or DONE) aborts it. The result is discarded, and no res_valid_o pulse follows reset release.
- States:
  - IDLE: req_ready_o=1. Accept when req_valid_i=1; operands and opcode are captured. Single-cycle op or illegal -> DONE. MUL -> MUL.
  - MUL: req_ready_o=0. One shift-add step per cycle over a 2*WORD_LEN accumulator; counter runs 0..WORD_LEN-1; after step WORD_LEN-1 -> DONE.
  - DONE: res_valid_o=1; outputs held stable until res_ready_i=1, then -> IDLE. req_ready_o=0; no request is accepted in the same cycle as the result handoff.
- Latency: single-cycle ops have res_valid_o high 1 cycle after accept. MUL has res_valid_o high WORD_LEN+1 cycles after accept. Throughput: one op per 2 cycles minimum.
- Operands are sampled only at accept; input changes afterwards have no effect.
- Arithmetic, all modulo 2^WORD_LEN:
  - ADD: c = carry out; v = sign(a)==sign(b) && sign(res)!=sign(a).
  - SUB: res = a-b; c = borrow (a <u b); v = sign(a)!=sign(b) && sign(res)!=sign(a).
  - AND/OR/XOR: c=v=0.
  - SHL/SHR/SAR: shift amount = op_b_i[SHAMT_LEN-1:0]; upper bits of op_b_i ignored. SHR zero-fills; SAR sign-fills; amount 0 passes A unchanged; c=v=0.
  - MUL: res = low WORD_LEN bits of unsigned a*b; c=1 iff high half nonzero; v=0.
- Flags z and n are computed from the final op_res_o for every legal op.
- Illegal opcode: res=0, err_o=1, all other flags 0; still completes with 1-cycle latency and normal handshake. err_o is cleared on the next accepted request.
- req_valid_i while req_ready_o=0 is ignored; the requester must hold it.

Test Plan:
- WORD_LEN=8: ADD a=0xFF, b=0x01 -> after 1 cycle res=0x00, z=1, c=1, v=0, n=0; ADD 0x7F+0x01 -> res=0x80, v=1, n=1, c=0.
- WORD_LEN=8: SUB 0x00-0x01 -> res=0xFF, c=1, n=1; SAR 0x80 by b=0xF3 (amount 3) -> res=0xF0; SHR same -> 0x10; SHL 0x01 by 0 -> 0x01.
- WORD_LEN=8: MUL 0x10*0x10 -> res_valid_o exactly 9 cycles after accept, res=0x00, c=1, z=1; MUL 0x0F*0x11 -> res=0xFF, c=0; req_ready_o=0 throughout.
- Back-pressure: hold res_ready_i=0 for 5 cycles after an XOR result -> res_valid_o and op_res_o stable; req_valid_i pulses in that window are not accepted; res_ready_i=1 -> IDLE next cycle.
- opc_i=12 -> res=0, err_o=1 after 1 cycle; next legal AND clears err_o.
- Assert rst_i at MUL step 4 -> outputs zero immediately (asynchronous), req_ready_o=1 after release, no spurious res_valid_o.
